// File: rtl/muldiv_sequencer.sv
// Iterative radix-2 multiply/divide engine with HI/LO write strobe and hazard stall.
// A start in Execute runs WIDTH shift cycles, one sign-fix cycle, then one write cycle.
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             startE,
  input  logic             multordivE,
  input  logic             signedE,
  input  logic [WIDTH-1:0] srca2E,
  input  logic [WIDTH-1:0] srcb2E,
  input  logic             mdopD,
  input  logic [1:0]       mfhlD,
  output logic             busy,
  output logic             stallmd,
  output logic [WIDTH-1:0] hiout,
  output logic [WIDTH-1:0] loout,
  output logic             hlwrite,
  output logic             divzero
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  opnd_q, opnd_d;   // |B|: addend for multiply, divisor for divide
  logic [WIDTH-1:0]  p_hi_q, p_hi_d;   // product high half / partial remainder
  logic [WIDTH-1:0]  p_lo_q, p_lo_d;   // |A| shifting out, product low half / quotient in
  logic              div_q, div_d;
  logic              neg_q, neg_d;
  logic              negr_q, negr_d;
  logic              dz_q, dz_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opnd_d  = opnd_q;
    p_hi_d  = p_hi_q;
    p_lo_d  = p_lo_q;
    div_d   = div_q;
    neg_d   = neg_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    a_mag = (signedE && srca2E[WIDTH-1]) ? -srca2E : srca2E;
    b_mag = (signedE && srcb2E[WIDTH-1]) ? -srcb2E : srcb2E;

    mul_sum   = {1'b0, p_hi_q} + (p_lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {p_hi_q, p_lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ge    = div_shift >= {1'b0, opnd_q};

    prod     = {p_hi_q, p_lo_q};
    prod_fix = neg_q ? -prod : prod;

    unique case (state_q)
      StIdle: begin
        if (startE) begin
          state_d = StRun;
          cnt_d   = '0;
          opnd_d  = b_mag;
          p_hi_d  = '0;
          p_lo_d  = a_mag;
          div_d   = multordivE;
          neg_d   = signedE && (srca2E[WIDTH-1] ^ srcb2E[WIDTH-1]);
          negr_d  = signedE && srca2E[WIDTH-1];
          dz_d    = multordivE && (srcb2E == '0);
        end
      end
      StRun: begin
        if (div_q) begin
          p_hi_d = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
          p_lo_d = {p_lo_q[WIDTH-2:0], div_ge};
        end else begin
          p_hi_d = mul_sum[WIDTH:1];
          p_lo_d = {mul_sum[0], p_lo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        if (div_q) begin
          hi_d = negr_q ? -p_hi_q : p_hi_q;
          // A zero divisor leaves LO as all ones regardless of sign.
          lo_d = (neg_q && !dz_q) ? -p_lo_q : p_lo_q;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      opnd_q  <= '0;
      p_hi_q  <= '0;
      p_lo_q  <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opnd_q  <= opnd_d;
      p_hi_q  <= p_hi_d;
      p_lo_q  <= p_lo_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      negr_q  <= negr_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy    = (state_q != StIdle);
  assign hlwrite = (state_q == StDone);
  assign divzero = hlwrite && dz_q;
  assign stallmd = ((mfhlD != 2'b00) || mdopD) && (busy || startE);
  assign hiout   = hi_q;
  assign loout   = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed and random ops against an arithmetic model.
module tb_muldiv_sequencer;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         startE;
  logic         multordivE;
  logic         signedE;
  logic [W-1:0] srca2E;
  logic [W-1:0] srcb2E;
  logic         mdopD;
  logic [1:0]   mfhlD;
  logic         busy;
  logic         stallmd;
  logic [W-1:0] hiout;
  logic [W-1:0] loout;
  logic         hlwrite;
  logic         divzero;

  int errors = 0;
  int checks = 0;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .startE     (startE),
    .multordivE (multordivE),
    .signedE    (signedE),
    .srca2E     (srca2E),
    .srcb2E     (srcb2E),
    .mdopD      (mdopD),
    .mfhlD      (mfhlD),
    .busy       (busy),
    .stallmd    (stallmd),
    .hiout      (hiout),
    .loout      (loout),
    .hlwrite    (hlwrite),
    .divzero    (divzero)
  );

  always #5 clk = ~clk;

  // The stall protocol must never let a new op reach Execute while the engine is occupied.
  always @(posedge clk) begin
    if (!reset && startE) begin
      assert (!busy) else $error("startE asserted while busy");
    end
  end

  // HI/LO as the instruction set defines them, computed with plain 64-bit arithmetic.
  function automatic logic [2*W-1:0] model(input logic dv, input logic sg,
                                           input logic [W-1:0] a, input logic [W-1:0] b);
    longint       la, lb, p, q, r;
    logic [63:0]  up;
    logic [W-1:0] hi, lo;
    if (!dv) begin
      if (sg) begin
        la = $signed(a);
        lb = $signed(b);
        p  = la * lb;
        up = p;
      end else begin
        up = {32'b0, a} * {32'b0, b};
      end
      hi = up[63:32];
      lo = up[31:0];
    end else if (b == '0) begin
      hi = a;
      lo = '1;
    end else if (sg) begin
      la = $signed(a);
      lb = $signed(b);
      q  = la / lb;
      r  = la % lb;
      up = q;
      lo = up[31:0];
      up = r;
      hi = up[31:0];
    end else begin
      lo = a / b;
      hi = a % b;
    end
    return {hi, lo};
  endfunction

  // kind: 0 = no dependent instruction, 1 = mfhi/mflo in Decode, 2 = mult/div in Decode.
  task automatic run_op(input logic dv, input logic sg, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int kind);
    logic [2*W-1:0] exp;
    logic           exp_stall;
    logic           exp_busy;
    logic           exp_wr;
    exp = model(dv, sg, a, b);
    @(negedge clk);
    startE     = 1'b1;
    multordivE = dv;
    signedE    = sg;
    srca2E     = a;
    srcb2E     = b;
    mfhlD      = (kind == 1) ? 2'b01 : 2'b00;
    mdopD      = (kind == 2);
    #1;
    checks++;
    if (stallmd !== (kind != 0)) begin
      errors++;
      $display("FAIL stall_c0 a=%h b=%h got=%b want=%b", a, b, stallmd, kind != 0);
    end
    for (int c = 1; c <= W + 3; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) startE = 1'b0;
      exp_busy  = (c <= W + 2);
      exp_wr    = (c == W + 2);
      exp_stall = (kind != 0) && exp_busy;
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL busy c=%0d got=%b want=%b", c, busy, exp_busy);
      end
      checks++;
      if (hlwrite !== exp_wr) begin
        errors++;
        $display("FAIL hlwrite c=%0d got=%b want=%b", c, hlwrite, exp_wr);
      end
      checks++;
      if (divzero !== (exp_wr && dv && (b == '0))) begin
        errors++;
        $display("FAIL divzero c=%0d got=%b want=%b", c, divzero, exp_wr && dv && (b == '0));
      end
      checks++;
      if (stallmd !== exp_stall) begin
        errors++;
        $display("FAIL stallmd c=%0d got=%b want=%b", c, stallmd, exp_stall);
      end
      if (c >= W + 2) begin
        checks++;
        if ({hiout, loout} !== exp) begin
          errors++;
          $display("FAIL result c=%0d dv=%b sg=%b a=%h b=%h got=%h_%h want=%h_%h",
                   c, dv, sg, a, b, hiout, loout, exp[2*W-1:W], exp[W-1:0]);
        end
      end
    end
    mfhlD = 2'b00;
    mdopD = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, stallmd, hlwrite, divzero} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got=%b want=0000", {busy, stallmd, hlwrite, divzero});
    end
    checks++;
    if ({hiout, loout} !== '0) begin
      errors++;
      $display("FAIL reset_hilo got=%h_%h want=0", hiout, loout);
    end
    reset = 1'b0;
  endtask

  task automatic test_mult();
    run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2, 0);
    run_op(1'b0, 1'b1, -32'sd3, 32'd5, 0);
    run_op(1'b0, 1'b0, -32'sd3, 32'd5, 0);
    run_op(1'b0, 1'b1, 32'h0, 32'h8000_0000, 0);
    run_op(1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 0);
  endtask

  task automatic test_div();
    run_op(1'b1, 1'b1, -32'sd7, 32'd2, 0);
    run_op(1'b1, 1'b0, 32'd100, 32'd7, 0);
    run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(1'b1, 1'b1, 32'd7, -32'sd2, 0);
  endtask

  task automatic test_divzero();
    run_op(1'b1, 1'b0, 32'h1234, 32'h0, 0);
    run_op(1'b1, 1'b1, -32'sd9, 32'h0, 0);
  endtask

  task automatic test_back_to_back();
    run_op(1'b0, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 1);
    run_op(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_0123, 2);
    run_op(1'b0, 1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 2);
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    startE     = 1'b1;
    multordivE = 1'b1;
    signedE    = 1'b0;
    srca2E     = 32'd100;
    srcb2E     = 32'd7;
    for (int c = 1; c <= W + 3; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) startE = 1'b0;
      if (c < 10) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL rst_busy_pre c=%0d got=%b want=1", c, busy);
        end
      end
      if (c == 10) reset = 1'b1;
      if (c == 11) begin
        reset = 1'b0;
        checks++;
        if ({hiout, loout} !== '0) begin
          errors++;
          $display("FAIL rst_hilo c=%0d got=%h_%h want=0", c, hiout, loout);
        end
      end
      if (c >= 11) begin
        checks++;
        if ({busy, hlwrite, divzero} !== 3'b000) begin
          errors++;
          $display("FAIL rst_abort c=%0d got=%b want=000", c, {busy, hlwrite, divzero});
        end
      end
    end
    run_op(1'b0, 1'b0, 32'd12345, 32'd678, 0);
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic         dv, sg;
    for (int i = 0; i < 24; i++) begin
      a  = $urandom;
      b  = $urandom;
      dv = $urandom_range(0, 1);
      sg = $urandom_range(0, 1);
      case ($urandom_range(0, 5))
        0: b = '0;
        1: b = $urandom_range(1, 15);
        2: a = {1'b1, 31'b0};
        3: b = '1;
        default: ;
      endcase
      run_op(dv, sg, a, b, $urandom_range(0, 2));
    end
  endtask

  initial begin
    reset      = 1'b1;
    startE     = 1'b0;
    multordivE = 1'b0;
    signedE    = 1'b0;
    srca2E     = '0;
    srcb2E     = '0;
    mdopD      = 1'b0;
    mfhlD      = 2'b00;
    test_reset();
    test_mult();
    test_div();
    test_divzero();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
